// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;
  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  localparam int ITER_W = 6;

  // op[1] selects divide, op[0] selects unsigned
  function automatic logic op_is_div(mdu_op_e op);
    return op[1];
  endfunction
endpackage

// File: rtl/mdu_if.sv
// Core <-> MDU request, HI/LO move and status bundle.
interface mdu_if import mdu_pkg::*; #(parameter int DATA_W = 32);
  logic              start;
  mdu_op_e           op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              hi_wr;
  logic              lo_wr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              div_by_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, src_a, src_b, hi_wr, lo_wr, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );
  modport slave (
    input  start, op, src_a, src_b, hi_wr, lo_wr, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
module mdu_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] sr,
  input  logic [DATA_W-1:0] opd,
  output logic [DATA_W-1:0] acc_nxt,
  output logic [DATA_W-1:0] sr_nxt
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] shl;
  logic            ge;

  always_comb begin
    sum     = sr[0] ? ({1'b0, acc} + {1'b0, opd}) : {1'b0, acc};
    // 33-bit partial remainder; remainder < divisor keeps the stored part at 32 bits
    shl     = {acc, sr[DATA_W-1]};
    ge      = (shl >= {1'b0, opd});
    acc_nxt = sum[DATA_W:1];
    sr_nxt  = {sum[0], sr[DATA_W-1:1]};
    if (is_div) begin
      acc_nxt = ge ? (shl[DATA_W-1:0] - opd) : shl[DATA_W-1:0];
      sr_nxt  = {sr[DATA_W-2:0], ge};
    end
  end
endmodule

// File: rtl/mdu_iter.sv
// Iterative mult/multu/div/divu unit owning the architectural HI/LO registers.
module mdu_iter import mdu_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ITER   = 32
) (
  input  logic clk,
  input  logic rst,
  mdu_if.slave bus
);
  mdu_state_e        state, state_nxt;
  logic [ITER_W-1:0] cnt;
  logic              is_div_q, neg_p, neg_r, dz_q;
  logic [DATA_W-1:0] acc, sr, opd, acc_nxt, sr_nxt;
  logic [DATA_W-1:0] hi_q, lo_q;
  logic              done_q, dz_out_q;

  logic              signed_op, req_div, last;
  logic [DATA_W-1:0] mag_a, mag_b, quo, rem;
  logic [2*DATA_W-1:0] prod;

  always_comb begin
    signed_op = ~bus.op[0];
    req_div   = op_is_div(bus.op);
    mag_a     = (signed_op && bus.src_a[DATA_W-1]) ? -bus.src_a : bus.src_a;
    mag_b     = (signed_op && bus.src_b[DATA_W-1]) ? -bus.src_b : bus.src_b;
    last      = (cnt == ITER_W'(ITER-1));
    prod      = neg_p ? -{acc, sr} : {acc, sr};
    quo       = neg_p ? -sr : sr;
    rem       = neg_r ? -acc : acc;
  end

  mdu_step #(.DATA_W(DATA_W)) u_step (
    .is_div (is_div_q),
    .acc    (acc),
    .sr     (sr),
    .opd    (opd),
    .acc_nxt(acc_nxt),
    .sr_nxt (sr_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_CALC;
      S_CALC:  if (last)      state_nxt = S_FIX;
      S_FIX:                  state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      is_div_q <= 1'b0;
      neg_p    <= 1'b0;
      neg_r    <= 1'b0;
      dz_q     <= 1'b0;
      acc      <= '0;
      sr       <= '0;
      opd      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // start takes priority over a same-cycle mthi/mtlo
          if (bus.start) begin
            cnt      <= '0;
            is_div_q <= req_div;
            neg_p    <= signed_op & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
            neg_r    <= signed_op & bus.src_a[DATA_W-1];
            dz_q     <= req_div & (bus.src_b == '0);
            acc      <= '0;
            sr       <= req_div ? mag_a : mag_b;
            opd      <= req_div ? mag_b : mag_a;
          end else begin
            if (bus.hi_wr) hi_q <= bus.wr_data;
            if (bus.lo_wr) lo_q <= bus.wr_data;
          end
        end
        S_CALC: begin
          acc <= acc_nxt;
          sr  <= sr_nxt;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          done_q   <= 1'b1;
          dz_out_q <= dz_q;
          if (!dz_q) begin
            if (is_div_q) begin
              hi_q <= rem;
              lo_q <= quo;
            end else begin
              {hi_q, lo_q} <= prod;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_out_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, owned by the multi-cycle MIPS core.
- Executes mult, multu, div and divu, and holds HI/LO for mfhi, mflo, mthi and mtlo.
- The core's FSM issues operands (the rs/rt read-data registers) with a start pulse, stalls on busy, and reads hi/lo directly.
- Radix-2 shift-add multiplier and restoring divider; one bit per cycle.

Parameters:
- DATA_W, 32: operand and HI/LO width. Only 32 is supported.
- ITER, 32: iteration count. Must equal DATA_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- op  in  2  00 mult, 01 multu, 10 div, 11 divu; sampled with start.
- src_a  in  32  rs value (multiplicand or dividend).
- src_b  in  32  rt value (multiplier or divisor).
- hi_wr  in  1  mthi write strobe.
- lo_wr  in  1  mtlo write strobe.
- wr_data  in  32  mthi/mtlo data.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO updated.
- div_by_zero  out  1  pulses with done when a div/divu had src_b==0.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0. All internal shift and accumulator registers are cleared. An in-flight operation is discarded.
- States: IDLE, CALC, FIX.
  - IDLE -> CALC on start.
  - CALC -> FIX after ITER iterations.
  - FIX -> IDLE unconditionally.
- Start cycle (cycle 0): the edge latches op, the operand magnitudes, the result-sign flags and the zero-divisor flag.
  - Signed ops (mult, div) take two's-complement magnitudes; unsigned ops use operands as-is.
  - Product sign = sign(a) XOR sign(b).
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Timing:
  - busy is high in cycles 1..33.
  - CALC occupies edges ending cycles 1..32.
  - The FIX edge ending cycle 33 applies sign correction and writes HI/LO.
  - done and div_by_zero are high in cycle 34 only; busy is low in cycle 34.
- Multiply: 64-bit {acc, multiplier} shift-add, one bit per cycle. HI = upper 32 bits of the result, LO = lower 32 bits. The 64-bit negate happens in FIX.
- Divide: restoring, 33-bit partial remainder; one quotient bit per iteration. LO = quotient, HI = remainder, both sign-corrected in FIX.
  - -2^31 / -1 gives LO=0x80000000, HI=0 (truncated, no flag).
- Divide by zero: full normal latency; HI and LO are left unchanged; div_by_zero=1 together with done.
- hi and lo keep their previous values throughout CALC and change only at FIX. The core may read them at any time.
- start while busy=1 (cycles 1..33) is ignored with no queuing. start in cycle 34 is accepted, since the unit is IDLE then.
- mthi/mtlo:
  - In IDLE, hi_wr/lo_wr write wr_data at the edge, visible the next cycle.
  - While busy, the write is ignored.
  - start together with hi_wr or lo_wr in the same cycle: start wins and the write is dropped.
  - hi_wr and lo_wr together both write wr_data.
- Invalid state encoding -> IDLE.

Decomposition:
- Package mdu_pkg holds:
  - op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - state encodings: S_IDLE, S_CALC, S_FIX;
  - ITER_W = 6 (iteration-counter width).
- One sub-module, mdu_step: combinational single-iteration datapath. Given mode, acc, shift register and operand, it returns the next acc and shift register (add-or-keep for multiply, trial-subtract/restore for divide). Top level keeps the FSM, counter, sign logic and HI/LO.

Test Plan:
- mult src_a=0xFFFFFFFD (-3), src_b=5, start in cycle 0 -> busy in cycles 1..33; done in cycle 34; HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; div_by_zero=0.
- div -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu 100/7 -> LO=0x0000000E, HI=0x00000002.
- mthi 0x12345678 and mtlo 0x9ABCDEF0 in IDLE, then divu 5/0 -> cycle 34: done=1, div_by_zero=1, HI=0x12345678, LO=0x9ABCDEF0 unchanged.
- Ignored requests: during a multu 3x4, pulse start (div) at cycle 10 and hi_wr at cycle 12 -> both ignored, done only at cycle 34, HI=0, LO=0x0000000C.
- start plus lo_wr in the same cycle: start wins, LO not written by mtlo.
- Reset at cycle 15 of a mult -> immediately busy=0, hi=lo=0; no done pulse. A following start completes normally in 34 cycles.
